branch_resolver: RTL and testbench
==================================

# branch_resolver

Execute-stage branch resolution unit, the consumer end of the 2-bit branch predictor. It captures each conditional branch leaving ID together with its predicted direction and evaluates the real condition in EX from forwarded operands. It then returns the training pair (update strobe + actual outcome) to the predictor, and on a misprediction issues a one-cycle flush plus a redirect PC to fetch. It also keeps branch and misprediction counters for performance evaluation.

## Interface
- CNT_W, 32, width of both performance counters (wrap-around)
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- id_opcode  in  6  opcode of ID instruction
- id_rt  in  5  rt field (REGIMM sub-op)
- id_pc  in  32  PC of ID instruction
- id_imm  in  16  branch offset field
- id_pred_taken  in  1  predictor's direction for this instruction
- stall  in  1  ID/EX hold; no capture and no resolution while high
- ex_rs_data  in  32  forwarded rs value for the instruction in EX
- ex_rt_data  in  32  forwarded rt value for the instruction in EX
- bp_update  out  1  one-cycle training strobe to predictor
- bp_actual  out  1  resolved direction, valid with bp_update
- flush  out  1  kill IF and ID contents (one cycle)
- redirect_pc  out  32  correct fetch address, valid with flush
- branch_count  out  CNT_W  resolved branches
- mispredict_count  out  CNT_W  resolved mispredictions

## Operation
- Branch opcodes: 0x04 BEQ (rs==rt), 0x05 BNE (rs!=rt), 0x06 BLEZ (rs<=0 signed), 0x07 BGTZ (rs>0 signed), 0x01 REGIMM with rt=0 BLTZ (rs<0), rt=1 BGEZ (rs>=0). REGIMM with any other rt is a non-branch.
- Capture: on a cycle with id_valid & !stall & !flush, the EX record loads valid=is_branch(id_opcode,id_rt), op, rt, pred=id_pred_taken, and target=id_pc+4+(sext(id_imm)<<2), using mod-2^32 arithmetic. It also stores fallthru=id_pc+8, which skips the delay slot.
- With id_valid=0 and !stall, the record loads valid=0. With stall, the record holds.
- While flush=1, the record loads valid=0. The wrong-path instruction in ID is discarded.
- Resolve: in a cycle with record valid & !stall, compute taken from ex_rs_data/ex_rt_data and set mispredict = taken ^ pred.
- Result registers, written the cycle after resolve:
  - bp_update=1 and bp_actual=taken.
  - flush=mispredict.
  - redirect_pc = taken ? target : fallthru.
  - branch_count += 1, and mispredict_count += mispredict.
- FSM with two states:
  - RUN: normal operation.
  - RECOVER: entered for exactly the cycle in which flush is high; returns to RUN unconditionally.
  - In RECOVER, captures are suppressed as above.
  - A branch sitting in EX during RECOVER (the delay slot; a branch in a delay slot is architecturally illegal) is dropped: no update, no count.
- Outputs that are not pulsing: bp_update=0, flush=0. bp_actual and redirect_pc hold their last values.

## Timing
- Reset values: bp_update=0, bp_actual=0, flush=0, redirect_pc=0, both counters 0, record valid=0, FSM=RUN.
- Latency: branch leaves ID at cycle T, resolves in EX at T+1 (if no stall), and bp_update/flush appear at T+2 for exactly one cycle.
- Pulses last one cycle regardless of stall. Downstream gives flush priority over stall.
- Stall while a branch is in EX delays resolution; there is exactly one update per branch.
- Back-to-back correctly predicted branches (in non-delay slots) produce consecutive update pulses.
- Counter overflow wraps to 0.
- Reset asserted mid-operation clears any pending pulse immediately (asynchronous).

## Structure
- Shared package `mips_pkg`: opcode constants OP_REGIMM/OP_BEQ/OP_BNE/OP_BLEZ/OP_BGTZ, REGIMM rt codes RT_BLTZ/RT_BGEZ, and an is_branch function. The predictor uses the same definitions.
- One combinational sub-module `branch_cond` (op, rt, rs_data, rt_data -> taken). Record registers, FSM, result registers and counters stay in branch_resolver.

## Test plan
- BEQ at pc 0x100, imm 0x0004, pred=0, rs=rt=5 -> at T+2: bp_update=1, bp_actual=1, flush=1, redirect_pc=0x114, mispredict_count=1.
- BNE at pc 0x200, pred=0, rs=rt -> at T+2: bp_update=1, bp_actual=0, flush=0, branch_count=1, mispredict_count=0.
- BLTZ, pred=1, rs=0 -> flush=1, redirect_pc=0x208 (pc+8). Same with imm=0xFFFF, rs=-1 -> bp_actual=1, no flush.
- Stall held 3 cycles with a branch in EX -> exactly one bp_update, 1 cycle after stall drops. Instruction in ID during the flush cycle is never resolved.
- Reset asserted in the cycle between resolve and pulse -> no flush and no update appear. Counters read 0.
- Non-branch opcodes and REGIMM rt=2 -> no bp_update, counters unchanged. Preload counters near 2^CNT_W-1 (CNT_W=4) -> wrap to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: branch opcodes, REGIMM sub-ops and the branch
// classification used by both the predictor and the resolver.
package mips_pkg;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    localparam logic [4:0] RT_BLTZ   = 5'd0;
    localparam logic [4:0] RT_BGEZ   = 5'd1;

    // Resolver control state: RECOVER covers exactly the flush cycle.
    typedef enum logic {
        ST_RUN,
        ST_RECOVER
    } br_state_e;

    // Conditional branch held in EX awaiting resolution.
    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [4:0]  rt;
        logic        pred;
        logic [31:0] target;
        logic [31:0] fallthru;
    } ex_rec_t;

    // True for the six conditional branch encodings; other REGIMM sub-ops are not branches.
    function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt);
        case (op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: return 1'b1;
            OP_REGIMM:                        return (rt == RT_BLTZ) || (rt == RT_BGEZ);
            default:                          return 1'b0;
        endcase
    endfunction

    // Taken target: address of the delay slot plus the word-scaled signed offset.
    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// ID/EX-side inputs and predictor/fetch-side results of the branch resolver.
interface branch_resolver_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [5:0]       id_opcode;
    logic [4:0]       id_rt;
    logic [31:0]      id_pc;
    logic [15:0]      id_imm;
    logic             id_pred_taken;
    logic             stall;
    logic [31:0]      ex_rs_data;
    logic [31:0]      ex_rt_data;
    logic             bp_update;
    logic             bp_actual;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    // Pipeline side: presents instructions and operands, consumes results.
    modport master (
        output id_valid, id_opcode, id_rt, id_pc, id_imm, id_pred_taken,
        output stall, ex_rs_data, ex_rt_data,
        input  bp_update, bp_actual, flush, redirect_pc,
        input  branch_count, mispredict_count
    );

    // Resolver side.
    modport slave (
        input  id_valid, id_opcode, id_rt, id_pc, id_imm, id_pred_taken,
        input  stall, ex_rs_data, ex_rt_data,
        output bp_update, bp_actual, flush, redirect_pc,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation on forwarded EX operands.
module branch_cond
    import mips_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rt,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        taken
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs_data[31];
    assign rs_zero = (rs_data == 32'd0);

    // Select the comparison implied by the opcode (and REGIMM sub-op).
    always_comb begin
        // NOTE: default assignment first so every path drives taken and no latch is inferred.
        taken = 1'b0;
        case (op)
            OP_BEQ:    taken = (rs_data == rt_data);
            OP_BNE:    taken = (rs_data != rt_data);
            OP_BLEZ:   taken = rs_neg || rs_zero;
            OP_BGTZ:   taken = !rs_neg && !rs_zero;
            OP_REGIMM: begin
                if (rt == RT_BLTZ) begin
                    taken = rs_neg;
                end else if (rt == RT_BGEZ) begin
                    taken = !rs_neg;
                end
            end
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: captures branches leaving ID, resolves them
// in EX, trains the predictor and redirects fetch on a misprediction.
module branch_resolver
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolver_if.slave bus
);

    ex_rec_t     rec;
    br_state_e   state;
    logic        taken;
    logic        resolve;
    logic        mispredict;

    branch_cond u_cond (
        .op      (rec.op),
        .rt      (rec.rt),
        .rs_data (bus.ex_rs_data),
        .rt_data (bus.ex_rt_data),
        .taken   (taken)
    );

    // A branch in EX during RECOVER is the delay slot and is dropped.
    assign resolve    = rec.valid && !bus.stall && (state == ST_RUN);
    assign mispredict = taken ^ rec.pred;

    // EX record: cleared during flush, held on stall, otherwise loaded from ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rec <= '0;
        end else if (state == ST_RECOVER) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            rec.valid <= 1'b0;
        end else if (!bus.stall) begin
            rec.valid    <= bus.id_valid && is_branch(bus.id_opcode, bus.id_rt);
            rec.op       <= bus.id_opcode;
            rec.rt       <= bus.id_rt;
            rec.pred     <= bus.id_pred_taken;
            rec.target   <= branch_target(bus.id_pc, bus.id_imm);
            rec.fallthru <= bus.id_pc + 32'd8;
        end
    end

    // FSM plus registered results: one-cycle pulses, held direction/redirect, counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= ST_RUN;
            bus.bp_update        <= 1'b0;
            bus.bp_actual        <= 1'b0;
            bus.flush            <= 1'b0;
            bus.redirect_pc      <= 32'd0;
            bus.branch_count     <= '0;
            bus.mispredict_count <= '0;
        end else begin
            bus.bp_update <= resolve;
            bus.flush     <= resolve && mispredict;

            case (state)
                ST_RUN:     if (resolve && mispredict) state <= ST_RECOVER;
                ST_RECOVER: state <= ST_RUN;
                default:    state <= ST_RUN;
            endcase

            if (resolve) begin
                bus.bp_actual        <= taken;
                bus.redirect_pc      <= taken ? rec.target : rec.fallthru;
                bus.branch_count     <= bus.branch_count + CNT_W'(1);
                bus.mispredict_count <= bus.mispredict_count + CNT_W'(mispredict);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: vector table, hand-built
// multi-cycle sequences and randomized branches against a reference model.
module tb_branch_resolver;

    localparam int CW = 4;
    localparam int CMOD = 1 << CW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_resolver_if #(.CNT_W(CW)) bus ();

    branch_resolver #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_bc = 0;
    int          m_mc = 0;
    logic        m_actual = 1'b0;
    logic [31:0] m_redirect = 32'd0;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [31:0] pc;
        logic [15:0] imm;
        logic        pred;
        logic [31:0] rs;
        logic [31:0] rtd;
        int          k;
        logic        upd;
        logic        actual;
        logic        fl;
        logic [31:0] redir;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit m_is_branch(input logic [5:0] op, input logic [4:0] rt);
        if (op == 6'd4 || op == 6'd5 || op == 6'd6 || op == 6'd7) return 1'b1;
        if (op == 6'd1 && (rt == 5'd0 || rt == 5'd1)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_taken(input logic [5:0] op, input logic [4:0] rt,
                                   input logic [31:0] rs, input logic [31:0] rtd);
        int s;
        s = rs;
        case (op)
            6'd4:    return rs == rtd;
            6'd5:    return rs != rtd;
            6'd6:    return s <= 0;
            6'd7:    return s > 0;
            6'd1:    return (rt == 5'd0) ? (s < 0) : (s >= 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc, input logic [15:0] imm);
        int off;
        off = $signed(imm);
        return pc + 32'd4 + 32'(off * 4);
    endfunction

    task automatic check_counts(input string name);
        check({name, "/bcount"}, 32'(bus.branch_count), 32'(m_bc));
        check({name, "/mcount"}, 32'(bus.mispredict_count), 32'(m_mc));
    endtask

    task automatic drive_id(input logic v, input logic [5:0] op, input logic [4:0] rt,
                            input logic [31:0] pc, input logic [15:0] imm, input logic pred);
        bus.id_valid      = v;
        bus.id_opcode     = op;
        bus.id_rt         = rt;
        bus.id_pc         = pc;
        bus.id_imm        = imm;
        bus.id_pred_taken = pred;
    endtask

    // One isolated instruction: ID at T, EX stalled k cycles, pulse checked, then quiet cycle checked.
    task automatic run_one(input string name, input logic [5:0] op, input logic [4:0] rt,
                           input logic [31:0] pc, input logic [15:0] imm, input logic pred,
                           input logic [31:0] rs, input logic [31:0] rtd, input int k,
                           input logic eu, input logic ea, input logic ef, input logic [31:0] er);
        drive_id(1'b1, op, rt, pc, imm, pred);
        bus.stall = 1'b0;
        @(posedge clk); #1;
        drive_id(1'b0, 6'd0, 5'd0, 32'd0, 16'd0, 1'b0);
        bus.ex_rs_data = rs;
        bus.ex_rt_data = rtd;
        bus.stall = (k > 0);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check({name, "/stall_upd"}, 32'(bus.bp_update), 32'd0);
            @(posedge clk); #1;
            if (i == k - 1) bus.stall = 1'b0;
        end
        @(posedge clk); #1;
        @(negedge clk);
        if (eu) begin
            m_bc = (m_bc + 1) % CMOD;
            if (ef) m_mc = (m_mc + 1) % CMOD;
            m_actual = ea;
            m_redirect = er;
        end
        check({name, "/upd"}, 32'(bus.bp_update), 32'(eu));
        check({name, "/actual"}, 32'(bus.bp_actual), 32'(ea));
        check({name, "/flush"}, 32'(bus.flush), 32'(ef));
        check({name, "/redirect"}, bus.redirect_pc, er);
        check_counts(name);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "/upd_after"}, 32'(bus.bp_update), 32'd0);
        check({name, "/flush_after"}, 32'(bus.flush), 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick(input logic [31:0] other);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return other;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  ops [8];
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [31:0] pc, rs, rtd, er;
        logic [15:0] imm;
        logic        pred, tk, eu, ea, ef;
        int          k;

        //            op     rt    pc         imm       pred rs            rtd    k  upd act fl  redirect
        vt[0]  = '{6'h04, 5'd5, 32'h100, 16'h0004, 1'b0, 32'd5,        32'd5, 0, 1'b1, 1'b1, 1'b1, 32'h114};
        vt[1]  = '{6'h05, 5'd7, 32'h200, 16'h0004, 1'b0, 32'd7,        32'd7, 0, 1'b1, 1'b0, 1'b0, 32'h208};
        vt[2]  = '{6'h01, 5'd0, 32'h200, 16'h0010, 1'b1, 32'd0,        32'd0, 0, 1'b1, 1'b0, 1'b1, 32'h208};
        vt[3]  = '{6'h01, 5'd0, 32'h200, 16'hFFFF, 1'b1, 32'hFFFFFFFF, 32'd0, 0, 1'b1, 1'b1, 1'b0, 32'h200};
        vt[4]  = '{6'h06, 5'd0, 32'h300, 16'h0002, 1'b0, 32'd0,        32'd3, 0, 1'b1, 1'b1, 1'b1, 32'h30C};
        vt[5]  = '{6'h07, 5'd0, 32'h400, 16'h0005, 1'b0, 32'h80000000, 32'd0, 0, 1'b1, 1'b0, 1'b0, 32'h408};
        vt[6]  = '{6'h01, 5'd1, 32'h500, 16'h0008, 1'b1, 32'd0,        32'd0, 0, 1'b1, 1'b1, 1'b0, 32'h524};
        vt[7]  = '{6'h01, 5'd2, 32'h600, 16'h0008, 1'b1, 32'd0,        32'd0, 0, 1'b0, 1'b1, 1'b0, 32'h524};
        vt[8]  = '{6'h08, 5'd0, 32'h600, 16'h0008, 1'b1, 32'd0,        32'd0, 0, 1'b0, 1'b1, 1'b0, 32'h524};
        vt[9]  = '{6'h04, 5'd2, 32'h600, 16'h0001, 1'b1, 32'd1,        32'd2, 3, 1'b1, 1'b0, 1'b1, 32'h608};
        vt[10] = '{6'h07, 5'd0, 32'h700, 16'h8000, 1'b1, 32'd1,        32'd0, 1, 1'b1, 1'b1, 1'b0, 32'hFFFE0704};

        ops = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h01, 6'h00, 6'h23};

        drive_id(1'b0, 6'd0, 5'd0, 32'd0, 16'd0, 1'b0);
        bus.stall = 1'b0;
        bus.ex_rs_data = 32'd0;
        bus.ex_rt_data = 32'd0;

        // Reset state
        #12;
        check("reset/upd", 32'(bus.bp_update), 32'd0);
        check("reset/flush", 32'(bus.flush), 32'd0);
        check("reset/actual", 32'(bus.bp_actual), 32'd0);
        check("reset/redirect", bus.redirect_pc, 32'd0);
        check_counts("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 11; i++) begin
            run_one($sformatf("vec%0d", i), vt[i].op, vt[i].rt, vt[i].pc, vt[i].imm, vt[i].pred,
                    vt[i].rs, vt[i].rtd, vt[i].k, vt[i].upd, vt[i].actual, vt[i].fl, vt[i].redir);
        end

        // Mispredict: delay-slot branch and wrong-path branch in ID must never resolve
        drive_id(1'b1, 6'h04, 5'd9, 32'h800, 16'h0004, 1'b0);
        @(posedge clk); #1;
        drive_id(1'b1, 6'h05, 5'd9, 32'h804, 16'h0004, 1'b0);
        bus.ex_rs_data = 32'd9;
        bus.ex_rt_data = 32'd9;
        @(posedge clk); #1;
        drive_id(1'b1, 6'h04, 5'd9, 32'h808, 16'h0004, 1'b0);
        @(negedge clk);
        m_bc = (m_bc + 1) % CMOD;
        m_mc = (m_mc + 1) % CMOD;
        m_actual = 1'b1;
        m_redirect = 32'h814;
        check("wrongpath/flush", 32'(bus.flush), 32'd1);
        check("wrongpath/upd", 32'(bus.bp_update), 32'd1);
        check("wrongpath/redirect", bus.redirect_pc, 32'h814);
        @(posedge clk); #1;
        drive_id(1'b0, 6'd0, 5'd0, 32'd0, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wrongpath/no_upd", 32'(bus.bp_update), 32'd0);
            check("wrongpath/no_flush", 32'(bus.flush), 32'd0);
            @(posedge clk); #1;
        end
        check_counts("wrongpath");

        // Back-to-back correctly predicted branches
        drive_id(1'b1, 6'h04, 5'd0, 32'h900, 16'h0003, 1'b1);
        @(posedge clk); #1;
        drive_id(1'b1, 6'h05, 5'd0, 32'h904, 16'hFFFE, 1'b1);
        bus.ex_rs_data = 32'd3;
        bus.ex_rt_data = 32'd3;
        @(posedge clk); #1;
        drive_id(1'b0, 6'd0, 5'd0, 32'd0, 16'd0, 1'b0);
        bus.ex_rs_data = 32'd1;
        bus.ex_rt_data = 32'd2;
        @(negedge clk);
        check("b2b/upd1", 32'(bus.bp_update), 32'd1);
        check("b2b/actual1", 32'(bus.bp_actual), 32'd1);
        check("b2b/flush1", 32'(bus.flush), 32'd0);
        check("b2b/redirect1", bus.redirect_pc, 32'h910);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b/upd2", 32'(bus.bp_update), 32'd1);
        check("b2b/actual2", 32'(bus.bp_actual), 32'd1);
        check("b2b/flush2", 32'(bus.flush), 32'd0);
        check("b2b/redirect2", bus.redirect_pc, 32'h900);
        m_bc = (m_bc + 2) % CMOD;
        m_actual = 1'b1;
        m_redirect = 32'h900;
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b/upd3", 32'(bus.bp_update), 32'd0);
        check_counts("b2b");
        @(posedge clk); #1;

        // Randomized branches against the reference model (counters wrap at 2^CW)
        for (int n = 0; n < 60; n++) begin
            op   = ops[$urandom_range(0, 7)];
            rt   = (op == 6'h01) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            pc   = $urandom & 32'hFFFF_FFFC;
            imm  = 16'($urandom);
            pred = 1'($urandom);
            rtd  = pick($urandom);
            rs   = pick(rtd);
            k    = $urandom_range(0, 2);
            if (m_is_branch(op, rt)) begin
                tk = m_taken(op, rt, rs, rtd);
                eu = 1'b1;
                ea = tk;
                ef = tk ^ pred;
                er = tk ? m_target(pc, imm) : pc + 32'd8;
            end else begin
                eu = 1'b0;
                ea = m_actual;
                ef = 1'b0;
                er = m_redirect;
            end
            run_one($sformatf("rnd%0d", n), op, rt, pc, imm, pred, rs, rtd, k, eu, ea, ef, er);
        end

        // Reset between resolve and pulse: nothing may appear
        drive_id(1'b1, 6'h04, 5'd0, 32'hA00, 16'h0004, 1'b0);
        @(posedge clk); #1;
        drive_id(1'b0, 6'd0, 5'd0, 32'd0, 16'd0, 1'b0);
        bus.ex_rs_data = 32'd4;
        bus.ex_rt_data = 32'd4;
        #2;
        reset = 1'b1;
        m_bc = 0;
        m_mc = 0;
        m_actual = 1'b0;
        m_redirect = 32'd0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid/upd", 32'(bus.bp_update), 32'd0);
        check("rst_mid/flush", 32'(bus.flush), 32'd0);
        check("rst_mid/redirect", bus.redirect_pc, 32'd0);
        check_counts("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid/upd_late", 32'(bus.bp_update), 32'd0);
        check("rst_mid/flush_late", 32'(bus.flush), 32'd0);
        @(posedge clk); #1;
        run_one("post_rst", 6'h05, 5'd0, 32'hB00, 16'h0002, 1'b1, 32'd1, 32'd2, 0,
                1'b1, 1'b1, 1'b0, 32'hB0C);

        // Asynchronous reset clears a live flush pulse without a clock edge
        drive_id(1'b1, 6'h07, 5'd0, 32'hC00, 16'h0001, 1'b1);
        @(posedge clk); #1;
        drive_id(1'b0, 6'd0, 5'd0, 32'd0, 16'd0, 1'b0);
        bus.ex_rs_data = 32'd0;
        @(posedge clk); #1;
        @(negedge clk);
        check("async/flush_on", 32'(bus.flush), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async/flush_off", 32'(bus.flush), 32'd0);
        check("async/upd_off", 32'(bus.bp_update), 32'd0);
        check("async/bcount", 32'(bus.branch_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
